fifo_param: RTL and testbench

- Parametrised synchronous FIFO built around the team's dual-pointer memory.
- Pointers move inside the block; the caller drives only read/write strobes.
- Adds full/empty/almost flags, occupancy count and sticky overflow/underflow error flags.
- Sits between producer and consumer stages of the datapath, one instance per channel.

---
 rtl/fifo_param.sv | 74 +++++++
 tb/tb_fifo_param.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous FIFO with occupancy count, almost flags and sticky errors.
// Optional high-water mark output peak_count when FIFO_PEAK_EN is defined.
module fifo_param #(
  parameter int BITNUMBER       = 10,
  parameter int LENGTH          = 8,
  parameter int PTR_W           = $clog2(LENGTH),
  parameter int ALMOST_FULL_TH  = 6,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write,
  input  logic                 read,
  input  logic [BITNUMBER-1:0] data_in,
  output logic [BITNUMBER-1:0] data_out,
  output logic [PTR_W-1:0]     ptr_write,
  output logic [PTR_W-1:0]     ptr_read,
  output logic [PTR_W:0]       count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
`ifdef FIFO_PEAK_EN
  output logic [PTR_W:0]       peak_count,
`endif
  output logic                 overflow_err,
  output logic                 underflow_err
);
  localparam logic [PTR_W:0] DEPTH = (PTR_W+1)'(LENGTH);
  localparam logic [PTR_W:0] AF_TH = (PTR_W+1)'(ALMOST_FULL_TH);
  localparam logic [PTR_W:0] AE_TH = (PTR_W+1)'(ALMOST_EMPTY_TH);
  logic [BITNUMBER-1:0] mem [LENGTH];
  logic                 rd_ok, wr_ok;
  logic [PTR_W:0]       count_nxt;
  assign full         = count == DEPTH;
  assign empty        = count == '0;
  assign almost_full  = count >= AF_TH;
  assign almost_empty = count <= AE_TH;
  // a read from a full FIFO frees the slot the simultaneous write lands in
  assign rd_ok = read & ~empty;
  assign wr_ok = write & (~full | rd_ok);
  always_comb begin
    count_nxt = (wr_ok && !rd_ok) ? count + 1'b1 :
                (rd_ok && !wr_ok) ? count - 1'b1 : count;
  end
  always_ff @(posedge clk) begin
    if (wr_ok) mem[ptr_write] <= data_in;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_write     <= '0;
      ptr_read      <= '0;
      count         <= '0;
      data_out      <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      count <= count_nxt;
      if (wr_ok) ptr_write <= ptr_write + 1'b1;
      if (rd_ok) begin
        data_out <= mem[ptr_read];
        ptr_read <= ptr_read + 1'b1;
      end
      if (write && !wr_ok) overflow_err <= 1'b1;
      if (read && empty) underflow_err <= 1'b1;
    end
  end
`ifdef FIFO_PEAK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) peak_count <= '0;
    else if (count_nxt > peak_count) peak_count <= count_nxt;
  end
`endif
endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed self-checking bench for fifo_param (default parameters).
module tb_fifo_param;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       write = 1'b0;
  logic       read = 1'b0;
  logic [9:0] data_in = '0;
  logic [9:0] data_out;
  logic [2:0] ptr_write, ptr_read;
  logic [3:0] count;
  logic       full, empty, almost_full, almost_empty, overflow_err, underflow_err;
`ifdef FIFO_PEAK_EN
  logic [3:0] peak_count;
`endif
  int checks = 0;
  int failures = 0;
  fifo_param dut (
    .clk(clk), .reset(reset), .write(write), .read(read), .data_in(data_in),
    .data_out(data_out), .ptr_write(ptr_write), .ptr_read(ptr_read), .count(count),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
`ifdef FIFO_PEAK_EN
    .peak_count(peak_count),
`endif
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    write = 1'b0;
    read  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  task automatic chk_reset_state(input string tag);
    chk({tag, "_ptr_write"}, 32'(ptr_write), 0);
    chk({tag, "_ptr_read"}, 32'(ptr_read), 0);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_data_out"}, 32'(data_out), 0);
    chk({tag, "_flags"}, {28'd0, full, empty, almost_full, almost_empty}, 32'b0101);
    chk({tag, "_errs"}, {30'd0, overflow_err, underflow_err}, 0);
  endtask
  initial begin
    do_reset();
    step();
    chk_reset_state("rst");
`ifdef FIFO_PEAK_EN
    chk("rst_peak", 32'(peak_count), 0);
`endif
    // fill with 0x001..0x008
    for (int i = 1; i <= 8; i++) begin
      write = 1'b1;
      data_in = 10'(i);
      step();
      chk($sformatf("fill%0d_count", i), 32'(count), 32'(i));
      chk($sformatf("fill%0d_af", i), 32'(almost_full), 32'(i >= 6));
      chk($sformatf("fill%0d_ae", i), 32'(almost_empty), 32'(i <= 2));
      chk($sformatf("fill%0d_full", i), 32'(full), 32'(i == 8));
    end
    chk("fill_ptr_wrap", 32'(ptr_write), 0);
    data_in = 10'h099;
    step();
    chk("ovf_err", 32'(overflow_err), 1);
    chk("ovf_count", 32'(count), 8);
    chk("ovf_ptr", 32'(ptr_write), 0);
    write = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      read = 1'b1;
      step();
      chk($sformatf("drain%0d_data", i), 32'(data_out), 32'(i));
      chk($sformatf("drain%0d_count", i), 32'(count), 32'(8 - i));
    end
    chk("drain_empty", 32'(empty), 1);
    chk("drain_no_udf", 32'(underflow_err), 0);
    step();
    chk("udf_err", 32'(underflow_err), 1);
    chk("udf_hold", 32'(data_out), 32'h008);
    chk("udf_count", 32'(count), 0);
    read = 1'b0;
    // write 5 / read 5 / write 6 / read 6 across the pointer wrap
    do_reset();
    for (int i = 1; i <= 5; i++) begin write = 1'b1; data_in = 10'(32'h10 + i); step(); end
    write = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      read = 1'b1;
      step();
      chk($sformatf("wrapA%0d_data", i), 32'(data_out), 32'h10 + i);
    end
    read = 1'b0;
    for (int i = 1; i <= 6; i++) begin write = 1'b1; data_in = 10'(32'h20 + i); step(); end
    write = 1'b0;
    chk("wrap_count6", 32'(count), 6);
    for (int i = 1; i <= 6; i++) begin
      read = 1'b1;
      step();
      chk($sformatf("wrapB%0d_data", i), 32'(data_out), 32'h20 + i);
    end
    read = 1'b0;
    chk("wrap_ptr_read", 32'(ptr_read), 3);
    chk("wrap_ptr_write", 32'(ptr_write), 3);
    chk("wrap_empty", 32'(empty), 1);
    // simultaneous read+write while full
    do_reset();
    for (int i = 1; i <= 8; i++) begin write = 1'b1; data_in = 10'(32'h30 + i); step(); end
    read = 1'b1;
    data_in = 10'h3FF;
    step();
    write = 1'b0;
    chk("rw_full_count", 32'(count), 8);
    chk("rw_full_flag", 32'(full), 1);
    chk("rw_full_ovf", 32'(overflow_err), 0);
    chk("rw_full_data", 32'(data_out), 32'h31);
    for (int i = 2; i <= 8; i++) begin
      step();
      chk($sformatf("rw_drain%0d", i), 32'(data_out), 32'h30 + i);
    end
    step();
    chk("rw_last", 32'(data_out), 32'h3FF);
    chk("rw_empty", 32'(empty), 1);
    read = 1'b0;
`ifdef FIFO_PEAK_EN
    chk("peak_full", 32'(peak_count), 8);
`endif
    // asynchronous reset mid-burst at count 4
    do_reset();
    for (int i = 1; i <= 5; i++) begin write = 1'b1; data_in = 10'(32'h40 + i); step(); end
    write = 1'b0;
    read = 1'b1;
    step();
    read = 1'b0;
    chk("mid_count", 32'(count), 4);
    chk("mid_data", 32'(data_out), 32'h41);
    write = 1'b1;
    data_in = 10'h055;
    #2;
    reset = 1'b1;
    #1;
    chk_reset_state("async");
`ifdef FIFO_PEAK_EN
    chk("async_peak", 32'(peak_count), 0);
`endif
    write = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk("post_rst_count", 32'(count), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
